// File: rtl/unified_buffer_nbank.sv
// N-bank activation/weight staging buffer with independent read and write burst engines.
// Optional per-byte write strobes (port wr_strb) are enabled by defining UB_WSTRB_EN.
module unified_buffer_nbank #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 128,
  parameter int NUM_BANKS  = 4,
  parameter int CNT_WIDTH  = 9,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BANK_BITS  = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic [BANK_BITS-1:0]  rd_bank,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  rd_req_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_done,
  input  logic                  wr_req,
  input  logic [BANK_BITS-1:0]  wr_bank,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [CNT_WIDTH-1:0]  wr_count,
  output logic                  wr_req_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  wr_done,
`ifdef UB_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
`endif
  output logic                  busy
);

  localparam int IDX_W = BANK_BITS + ADDR_WIDTH;
  localparam int WORDS = NUM_BANKS * DEPTH;

  typedef enum logic {RD_IDLE, RD_FETCH} rd_state_e;
  typedef enum logic {WR_IDLE, WR_BURST} wr_state_e;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  rd_state_e             rd_state_q, rd_state_d;
  logic [BANK_BITS-1:0]  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_WIDTH-1:0]  rd_rem_q, rd_rem_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  wr_state_e             wr_state_q, wr_state_d;
  logic [BANK_BITS-1:0]  wr_bank_q, wr_bank_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_WIDTH-1:0]  wr_rem_q, wr_rem_d;
  logic                  wr_done_q, wr_done_d;

  logic             rd_busy, wr_hold;
  logic             rd_accept, wr_accept;
  logic             rd_out_free, rd_issue, wr_fire;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  assign rd_idx   = {rd_bank_q, rd_addr_q};
  assign wr_idx   = {wr_bank_q, wr_addr_q};
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wr_done  = wr_done_q;
  assign wr_ready = (wr_state_q == WR_BURST);
  assign wr_fire  = wr_ready && wr_valid;

  // Bank-conflict interlocks; a same-cycle same-bank request pair goes to the write.
  always_comb begin
    rd_busy      = (rd_state_q != RD_IDLE);
    wr_hold      = (wr_state_q != WR_IDLE) || wr_done_q;
    wr_req_ready = (wr_state_q == WR_IDLE)
                && !(rd_busy && rd_bank_q == wr_bank);
    wr_accept    = wr_req && wr_req_ready;
    rd_req_ready = !rd_busy
                && !(wr_hold && wr_bank_q == rd_bank)
                && !(wr_accept && wr_bank == rd_bank);
    rd_accept    = rd_req && rd_req_ready;
    busy         = rd_busy || (wr_state_q != WR_IDLE);
  end

  // Read engine: issue a fetch whenever the output register is free.
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_addr_d   = rd_addr_q;
    rd_rem_d    = rd_rem_q;
    rd_valid_d  = rd_valid_q;
    rd_out_free = !rd_valid_q || rd_ready;
    rd_issue    = 1'b0;
    rd_done     = 1'b0;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (rd_accept) begin
          rd_state_d = RD_FETCH;
          rd_bank_d  = rd_bank;
          rd_addr_d  = rd_addr;
          rd_rem_d   = rd_count;
        end
      end
      RD_FETCH: begin
        if (rd_out_free) begin
          if (rd_rem_q != '0) begin
            rd_issue  = 1'b1;
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            rd_rem_d  = rd_rem_q - CNT_WIDTH'(1);
          end else begin
            rd_done    = 1'b1;
            rd_state_d = RD_IDLE;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    if (rd_issue) begin
      rd_valid_d = 1'b1;
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  // Read engine state and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      rd_bank_q  <= '0;
      rd_addr_q  <= '0;
      rd_rem_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_addr_q  <= rd_addr_d;
      rd_rem_q   <= rd_rem_d;
      rd_valid_q <= rd_valid_d;
      if (rd_issue) begin
        rd_data_q <= mem_q[rd_idx];
      end
    end
  end

  // Write engine: one word per accepted beat, done one cycle after the last beat.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    wr_addr_d  = wr_addr_q;
    wr_rem_d   = wr_rem_q;
    wr_done_d  = 1'b0;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (wr_accept) begin
          wr_bank_d = wr_bank;
          wr_addr_d = wr_addr;
          wr_rem_d  = wr_count;
          if (wr_count == '0) begin
            wr_done_d = 1'b1;
          end else begin
            wr_state_d = WR_BURST;
          end
        end
      end
      WR_BURST: begin
        if (wr_fire) begin
          wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          wr_rem_d  = wr_rem_q - CNT_WIDTH'(1);
          if (wr_rem_q == CNT_WIDTH'(1)) begin
            wr_state_d = WR_IDLE;
            wr_done_d  = 1'b1;
          end
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Write engine state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      wr_bank_q  <= '0;
      wr_addr_q  <= '0;
      wr_rem_q   <= '0;
      wr_done_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_bank_q  <= wr_bank_d;
      wr_addr_q  <= wr_addr_d;
      wr_rem_q   <= wr_rem_d;
      wr_done_q  <= wr_done_d;
    end
  end

  // Bank storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
`ifdef UB_WSTRB_EN
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_strb[b]) begin
          mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
`else
      mem_q[wr_idx] <= wr_data;
`endif
    end
  end

endmodule

// File: tb/tb_unified_buffer_nbank.sv
// Randomised self-checking bench for unified_buffer_nbank.
// A word-array model of every bank supplies the expected read data.
module tb_unified_buffer_nbank;

  localparam int DW = 256;
  localparam int D  = 128;
  localparam int NB = 4;
  localparam int CW = 9;
  localparam int AW = 7;
  localparam int BB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req = 1'b0;
  logic [BB-1:0] rd_bank = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [CW-1:0] rd_count = '0;
  logic          rd_req_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          rd_done;
  logic          wr_req = 1'b0;
  logic [BB-1:0] wr_bank = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_count = '0;
  logic          wr_req_ready;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          wr_done;
  logic          busy;
  logic [DW/8-1:0] strb_tb = '1;

  int n_chk = 0;
  int n_pass = 0;
  logic [DW-1:0] model [NB][D];

  always #5 clk = ~clk;

  unified_buffer_nbank dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_count(rd_count), .rd_req_ready(rd_req_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_done(rd_done),
    .wr_req(wr_req), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_count(wr_count), .wr_req_ready(wr_req_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_done(wr_done),
`ifdef UB_WSTRB_EN
    .wr_strb(strb_tb),
`endif
    .busy(busy)
  );

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic do_bursts(
    input bit dw, input int wb, input int wa, input int wc,
    input bit dr, input int rb, input int ra, input int rc,
    input int vpct, input int rpct, input int stall_beat,
    input bit incr, input logic [DW-1:0] dbase,
    output int wacc_cyc, output int racc_cyc,
    output int wdone_cyc, output int rdone_cyc);
    logic [DW-1:0] expq [$];
    logic [DW-1:0] hold_d;
    logic [DW-1:0] e;
    bit wacc, racc, wfin, rfin, stall, exp_rdone;
    int cyc, wsent, rgot, wlast, stall_n, widx;
    int limit;
    limit = 40 * (wc + rc) + 100;
    wacc = !dw; racc = !dr; wfin = !dw; rfin = !dr;
    stall = 0; cyc = 0; wsent = 0; rgot = 0;
    wlast = -10; stall_n = 0; hold_d = '0;
    wacc_cyc = -1; racc_cyc = -1; wdone_cyc = -1; rdone_cyc = -1;
    while (!(wfin && rfin) && cyc < limit) begin
      @(negedge clk);
      if (stall) begin
        n_chk++;
        if (rd_valid !== 1'b1 || rd_data !== hold_d)
          $display("FAIL hold: valid=%b data=%h want %h",
                   rd_valid, rd_data, hold_d);
        else n_pass++;
      end
      wr_req   = dw && !wacc;
      wr_bank  = BB'(wb);
      wr_addr  = AW'(wa);
      wr_count = CW'(wc);
      rd_req   = dr && !racc;
      rd_bank  = BB'(rb);
      rd_addr  = AW'(ra);
      rd_count = CW'(rc);
      wr_valid = dw && wacc && (wsent < wc)
              && ($urandom_range(99) < vpct);
      wr_data  = incr ? dbase + DW'(wsent) : rnd_word();
      if (rgot == stall_beat && stall_n < 2) rd_ready = 1'b0;
      else rd_ready = ($urandom_range(99) < rpct);
      #1;
      exp_rdone = racc && !rfin &&
        ((rc == 0) ? (cyc == racc_cyc + 1)
                   : (rd_valid && rd_ready && expq.size() == 1));
      if (rd_done || exp_rdone) begin
        n_chk++;
        if (rd_done !== exp_rdone)
          $display("FAIL rd_done: got %b want %b cyc %0d",
                   rd_done, exp_rdone, cyc);
        else n_pass++;
      end
      if (rd_valid && expq.size() == 0) begin
        n_chk++;
        $display("FAIL spurious rd_valid: got 1 want 0 cyc %0d", cyc);
      end
      if (rd_valid && rd_ready && expq.size() > 0) begin
        e = expq.pop_front();
        n_chk++;
        if (rd_data !== e)
          $display("FAIL rd beat %0d: got %h want %h", rgot, rd_data, e);
        else n_pass++;
        rgot++;
      end
      if (rd_valid && !rd_ready && rgot == stall_beat) stall_n++;
      if (wr_valid && wr_ready) begin
        widx = (wa + wsent) % D;
        for (int b = 0; b < DW/8; b++)
          if (strb_tb[b]) model[wb][widx][b*8 +: 8] = wr_data[b*8 +: 8];
        wsent++;
        if (wsent == wc) wlast = cyc;
      end
      if (wr_done) begin
        n_chk++;
        if (!wacc || wfin || cyc != wlast + 1)
          $display("FAIL wr_done: at cyc %0d want %0d", cyc, wlast + 1);
        else n_pass++;
        wfin = 1;
        wdone_cyc = cyc;
      end
      if (rd_done) begin
        rfin = 1;
        rdone_cyc = cyc;
      end
      if (wr_req && wr_req_ready) begin
        wacc = 1;
        wacc_cyc = cyc;
        if (wc == 0) wlast = cyc;
      end
      if (rd_req && rd_req_ready) begin
        racc = 1;
        racc_cyc = cyc;
        for (int i = 0; i < rc; i++) expq.push_back(model[rb][(ra + i) % D]);
      end
      stall  = rd_valid && !rd_ready;
      hold_d = rd_data;
      cyc++;
    end
    n_chk++;
    if (cyc >= limit)
      $display("FAIL timeout: got %0d cycles want < %0d", cyc, limit);
    else n_pass++;
    n_chk++;
    if (rgot != (dr ? rc : 0) || expq.size() != 0)
      $display("FAIL beat count: got %0d want %0d", rgot, dr ? rc : 0);
    else n_pass++;
    @(negedge clk);
    wr_req = 0; rd_req = 0; wr_valid = 0; rd_ready = 1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (rd_valid !== 1'b0 || rd_done !== 1'b0 || wr_done !== 1'b0)
      $display("FAIL reset flags: got v%b rd%b wd%b want 000",
               rd_valid, rd_done, wr_done);
    else n_pass++;
    n_chk++;
    if (wr_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset ready/busy: got %b%b want 00", wr_ready, busy);
    else n_pass++;
    n_chk++;
    if (rd_data !== '0)
      $display("FAIL reset rd_data: got %h want 0", rd_data);
    else n_pass++;
    n_chk++;
    if (rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1)
      $display("FAIL reset req_ready: got %b%b want 11",
               rd_req_ready, wr_req_ready);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0 || rd_req_ready !== 1'b1)
      $display("FAIL post-reset: got busy %b rrr %b want 0 1",
               busy, rd_req_ready);
    else n_pass++;
  endtask

  task automatic test_fill;
    int a0, a1, a2, a3;
    for (int b = 0; b < NB; b++)
      do_bursts(1, b, 0, D, 0, 0, 0, 0, 100, 100, -1, 0, '0,
                a0, a1, a2, a3);
  endtask

  task automatic test_basic;
    int wa_c, ra_c, wd_c, rd_c;
    do_bursts(1, 2, 5, 4, 0, 0, 0, 0, 100, 100, -1, 1, DW'('hA0),
              wa_c, ra_c, wd_c, rd_c);
    do_bursts(0, 0, 0, 0, 1, 2, 5, 4, 100, 100, -1, 0, '0,
              wa_c, ra_c, wd_c, rd_c);
    n_chk++;
    if (rd_c != ra_c + 5)
      $display("FAIL basic rd_done cyc: got %0d want %0d", rd_c, ra_c + 5);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int wa_c, ra_c, wd_c, rd_c;
    do_bursts(1, 1, 40, 3, 0, 0, 0, 0, 100, 100, -1, 0, '0,
              wa_c, ra_c, wd_c, rd_c);
    do_bursts(0, 0, 0, 0, 1, 1, 40, 3, 100, 100, 1, 0, '0,
              wa_c, ra_c, wd_c, rd_c);
    n_chk++;
    if (rd_c != ra_c + 6)
      $display("FAIL stall rd_done cyc: got %0d want %0d", rd_c, ra_c + 6);
    else n_pass++;
  endtask

  task automatic test_wrap;
    int wa_c, ra_c, wd_c, rd_c;
    do_bursts(1, 3, D - 2, 3, 0, 0, 0, 0, 70, 100, -1, 0, '0,
              wa_c, ra_c, wd_c, rd_c);
    do_bursts(0, 0, 0, 0, 1, 3, D - 2, 3, 100, 100, -1, 0, '0,
              wa_c, ra_c, wd_c, rd_c);
    do_bursts(0, 0, 0, 0, 1, 3, 0, D, 100, 100, -1, 0, '0,
              wa_c, ra_c, wd_c, rd_c);
    do_bursts(0, 0, 0, 0, 1, 2, 0, D, 100, 100, -1, 0, '0,
              wa_c, ra_c, wd_c, rd_c);
  endtask

  task automatic test_conflict;
    int wa_c, ra_c, wd_c, rd_c;
    do_bursts(1, 0, 60, 4, 1, 0, 60, 4, 100, 100, -1, 0, '0,
              wa_c, ra_c, wd_c, rd_c);
    n_chk++;
    if (wa_c != 0)
      $display("FAIL conflict wr accept: got %0d want 0", wa_c);
    else n_pass++;
    n_chk++;
    if (ra_c != wd_c + 1)
      $display("FAIL conflict rd accept: got %0d want %0d", ra_c, wd_c + 1);
    else n_pass++;
  endtask

  task automatic test_concurrent;
    int wa_c, ra_c, wd_c, rd_c;
    do_bursts(1, 0, 10, 8, 1, 3, 20, 8, 100, 100, -1, 0, '0,
              wa_c, ra_c, wd_c, rd_c);
    n_chk++;
    if (wa_c != 0 || ra_c != 0)
      $display("FAIL concurrent accept: got %0d %0d want 0 0", wa_c, ra_c);
    else n_pass++;
    n_chk++;
    if (wd_c != 9 || rd_c != 9)
      $display("FAIL concurrent done: got %0d %0d want 9 9", wd_c, rd_c);
    else n_pass++;
  endtask

  task automatic test_count0;
    int wa_c, ra_c, wd_c, rd_c;
    do_bursts(1, 1, 3, 0, 1, 2, 7, 0, 100, 100, -1, 0, '0,
              wa_c, ra_c, wd_c, rd_c);
    n_chk++;
    if (wd_c != wa_c + 1 || rd_c != ra_c + 1)
      $display("FAIL count0 done: got %0d %0d want %0d %0d",
               wd_c, rd_c, wa_c + 1, ra_c + 1);
    else n_pass++;
    do_bursts(0, 0, 0, 0, 1, 1, 0, D, 100, 100, -1, 0, '0,
              wa_c, ra_c, wd_c, rd_c);
  endtask

  task automatic test_reset_mid;
    int wa_c, ra_c, wd_c, rd_c;
    logic [DW-1:0] d;
    @(negedge clk);
    wr_req = 1; wr_bank = 1; wr_addr = 10; wr_count = 6;
    #1;
    n_chk++;
    if (wr_req_ready !== 1'b1)
      $display("FAIL mid wr_req_ready: got %b want 1", wr_req_ready);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wr_req = 0;
      d = rnd_word();
      wr_valid = 1; wr_data = d;
      #1;
      n_chk++;
      if (wr_ready !== 1'b1)
        $display("FAIL mid wr_ready beat %0d: got %b want 1", k, wr_ready);
      else n_pass++;
      if (wr_ready) model[1][10 + k] = d;
    end
    @(negedge clk);
    wr_data = rnd_word();
    rst_n = 0;
    #1;
    n_chk++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b0)
      $display("FAIL mid reset: got v%b busy%b wr%b want 000",
               rd_valid, busy, wr_ready);
    else n_pass++;
    repeat (2) @(negedge clk);
    wr_valid = 0;
    rst_n = 1;
    do_bursts(0, 0, 0, 0, 1, 1, 10, 6, 100, 100, -1, 0, '0,
              wa_c, ra_c, wd_c, rd_c);
  endtask

`ifdef UB_WSTRB_EN
  task automatic test_strobe;
    int wa_c, ra_c, wd_c, rd_c;
    logic [DW-1:0] ones;
    ones = '1;
    strb_tb = '1;
    do_bursts(1, 0, 20, 1, 0, 0, 0, 0, 100, 100, -1, 1, '0,
              wa_c, ra_c, wd_c, rd_c);
    strb_tb = DW/8'('h0F);
    do_bursts(1, 0, 20, 1, 0, 0, 0, 0, 100, 100, -1, 1, ones,
              wa_c, ra_c, wd_c, rd_c);
    strb_tb = '1;
    do_bursts(0, 0, 0, 0, 1, 0, 20, 1, 100, 100, -1, 0, '0,
              wa_c, ra_c, wd_c, rd_c);
  endtask
`endif

  task automatic test_random;
    int wa_c, ra_c, wd_c, rd_c;
    bit dw, dr;
    for (int it = 0; it < 16; it++) begin
      dw = bit'($urandom_range(1));
      dr = bit'($urandom_range(1));
      if (!dw && !dr) dw = 1;
      do_bursts(dw, $urandom_range(NB - 1), $urandom_range(D - 1),
                $urandom_range(200),
                dr, $urandom_range(NB - 1), $urandom_range(D - 1),
                $urandom_range(200),
                $urandom_range(40, 100), $urandom_range(40, 100),
                -1, 0, '0, wa_c, ra_c, wd_c, rd_c);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_backpressure();
    test_wrap();
    test_conflict();
    test_concurrent();
    test_count0();
    test_reset_mid();
`ifdef UB_WSTRB_EN
    test_strobe();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/unified_buffer_nbank.md
Name: unified_buffer_nbank

Overview:
Parametrised successor to the two-bank unified buffer, with N banks of single-port-style BRAM. It provides independent read and write burst engines, each with valid/ready beat handshakes, and accepts fresh write data on every beat. Bank-conflict interlocks stop a read and a write from ever targeting the same bank at the same time. It sits between the host/UART loader, the controller and the systolic array as the activation/weight staging store.

Parameters:
- DATA_WIDTH, 256, word width in bits; must be a multiple of 8.
- DEPTH, 128, words per bank; must be a power of 2.
- NUM_BANKS, 4, number of banks; must be a power of 2 and at least 2.
- CNT_WIDTH, 9, burst-count width.
- ADDR_WIDTH, $clog2(DEPTH), derived; word address within a bank.
- BANK_BITS, $clog2(NUM_BANKS), derived; bank select width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  read burst request
- rd_bank  in  BANK_BITS  target bank of the read burst
- rd_addr  in  ADDR_WIDTH  start word address of the read burst
- rd_count  in  CNT_WIDTH  read burst length in beats
- rd_req_ready  out  1  read request accepted when rd_req && rd_req_ready
- rd_data  out  DATA_WIDTH  read beat data
- rd_valid  out  1  read beat valid
- rd_ready  in  1  consumer accepts read beat
- rd_done  out  1  one-cycle pulse at end of read burst
- wr_req  in  1  write burst request
- wr_bank  in  BANK_BITS  target bank of the write burst
- wr_addr  in  ADDR_WIDTH  start word address of the write burst
- wr_count  in  CNT_WIDTH  write burst length in beats
- wr_req_ready  out  1  write request accepted when wr_req && wr_req_ready
- wr_data  in  DATA_WIDTH  write beat data
- wr_valid  in  1  write beat valid
- wr_ready  out  1  buffer accepts write beat
- wr_done  out  1  one-cycle pulse after the last write beat
- busy  out  1  either engine not idle

Behaviour:
- Reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. While reset is asserted, both FSMs go to IDLE, all counters clear, and outputs take these values:
  - rd_valid=0, rd_done=0, wr_done=0, wr_ready=0, busy=0
  - rd_data=0
  - rd_req_ready=1, wr_req_ready=1
  - Memory contents are not cleared.
- Reset asserted mid-burst: the burst is abandoned; no further beats are written or presented.
- Request acceptance:
  - Each engine latches bank, address and count on acceptance. Later changes on rd_*/wr_* request inputs have no effect on an accepted burst.
  - rd_req_ready = rd_idle && !(wr_busy && wr_bank_q==rd_bank).
  - wr_req_ready = wr_idle && !(rd_busy && rd_bank_q==wr_bank).
  - Both engines idle and rd_req && wr_req to the same bank in the same cycle: the write is accepted and the read is held off until wr_done.
- Read FSM: IDLE -> FETCH -> IDLE.
  - FETCH issues one memory read per cycle only when the output register is free: !rd_valid || rd_ready.
  - rd_data/rd_valid are registered, so the first beat appears 1 cycle after the first issue.
  - rd_valid and rd_data hold stable while rd_ready=0.
  - rd_done pulses in the cycle the last beat is consumed (rd_valid && rd_ready on the final beat). The FSM stays non-idle until then.
- Write FSM: IDLE -> BURST -> IDLE.
  - wr_ready=1 only in BURST.
  - Each cycle with wr_valid && wr_ready writes wr_data to the current address and decrements the remaining count.
  - Gaps in wr_valid insert no writes.
  - After the last beat the FSM returns to IDLE and wr_done pulses in the following cycle.
- Address arithmetic: the current address increments modulo DEPTH, wrapping DEPTH-1 -> 0 within the same bank. A burst never crosses into another bank.
- Count 0: request is accepted, no beats occur, and the done pulse fires 1 cycle after acceptance.
- Count > DEPTH: legal; addresses wrap and overwrite or re-read earlier words.
- Read and write engines operating on different banks run fully concurrently with no throughput loss.
- busy = !rd_idle || !wr_idle.
- Each bank is inferred as block RAM with one write port and one registered read port.

Optional Feature:
- UB_WSTRB_EN defined:
  - Adds input port wr_strb [DATA_WIDTH/8-1:0].
  - Each accepted write beat updates only the bytes whose strobe bit is 1; all other bytes of the word keep their value.
- UB_WSTRB_EN undefined: the port is absent and every accepted beat writes the full word.

Test Plan:
- Write bank 2, addr 5, count 4, data 0xA0..0xA3 back-to-back; then read the same burst -> rd_data 0xA0,0xA1,0xA2,0xA3; wr_done and rd_done each pulse once.
- Read bank 1, count 3, with rd_ready low for 2 cycles on beat 2 -> beat 2 is held stable, no beat is lost or duplicated, rd_done follows beat 3.
- Write addr DEPTH-2, count 3 -> words land at DEPTH-2, DEPTH-1 and 0 of the same bank; other banks are unchanged.
- Simultaneous rd_req/wr_req to bank 0 -> write accepted; rd_req_ready=0 until the cycle after wr_done; the read then returns the new data. Write to bank 0 while reading bank 3 -> both proceed concurrently.
- Count 0 read and write -> no rd_valid, no memory change, done pulse 1 cycle after acceptance.
- rst_n pulsed low mid write burst -> immediate idle, rd_valid=0, busy=0, remaining beats not written. With UB_WSTRB_EN, strb 0x0F on 0xFF..FF over 0 -> only the low 4 bytes are set.
